param_address_register_file: RTL and testbench

PARAM_ADDRESS_REGISTER_FILE -- requirements
Module: param_address_register_file

---
 rtl/addr_rf_pkg.sv | 29 ++
 rtl/addr_reg_cell.sv | 77 +++++++
 rtl/param_address_register_file.sv | 67 ++++++
 tb/tb_param_address_register_file.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addr_rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addr_rf_pkg
// Description : Shared operation codes and select-width helper for the
//               address register file.
// Revision    : 1.0 - initial release
// ============================================================================
package addr_rf_pkg;

    typedef enum logic [2:0] {
        FS_DEC        = 3'b000,
        FS_INC        = 3'b001,
        FS_LOAD       = 3'b010,
        FS_CLR        = 3'b011,
        FS_LOAD_LO_ZX = 3'b100,
        FS_WR_LO      = 3'b101,
        FS_WR_HI      = 3'b110,
        FS_LOAD_LO_SX = 3'b111
    } funsel_e;

    localparam int c_FUNSEL_W = 3;

    // Never let a select port collapse to zero bits.
    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage : addr_rf_pkg
`default_nettype wire

// File: rtl/addr_reg_cell.sv
`default_nettype none
// ============================================================================
// Module      : addr_reg_cell
// Description : One address register with operation decode and sticky wrap
//               flag.
// Revision    : 1.0 - initial release
// ============================================================================
module addr_reg_cell
    import addr_rf_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    input  funsel_e          i_funsel,
    input  logic             i_en,
    input  logic             i_flag_clr,
    output logic [WIDTH-1:0] o_q,
    output logic             o_wrap
);

    logic [WIDTH-1:0] r_q;
    logic             r_flag;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap;
    logic             w_set;
    logic             w_clr;

    always_comb begin
        w_next = r_q;
        w_wrap = 1'b0;
        case (i_funsel)
            FS_DEC: begin
                w_next = r_q - WIDTH'(1);
                w_wrap = (r_q == '0);
            end
            FS_INC: begin
                w_next = r_q + WIDTH'(1);
                w_wrap = (r_q == '1);
            end
            FS_LOAD:       w_next = i_data;
            FS_CLR:        w_next = '0;
            FS_LOAD_LO_ZX: w_next = {{(WIDTH-8){1'b0}}, i_data[7:0]};
            FS_WR_LO:      w_next = {r_q[WIDTH-1:8], i_data[7:0]};
            FS_WR_HI:      w_next = {i_data[WIDTH-1:8], r_q[7:0]};
            FS_LOAD_LO_SX: w_next = {{(WIDTH-8){i_data[7]}}, i_data[7:0]};
            default:       w_next = r_q;
        endcase
    end

    // A wrap in the same cycle as any clear source leaves the flag set.
    assign w_set = i_en & w_wrap;
    assign w_clr = i_flag_clr | (i_en & ((i_funsel == FS_LOAD) || (i_funsel == FS_CLR)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= RESET_VAL;
            r_flag <= 1'b0;
        end else begin
            if (i_en) begin
                r_q <= w_next;
            end
            if (w_set) begin
                r_flag <= 1'b1;
            end else if (w_clr) begin
                r_flag <= 1'b0;
            end
        end
    end

    assign o_q    = r_q;
    assign o_wrap = r_flag;

endmodule : addr_reg_cell
`default_nettype wire

// File: rtl/param_address_register_file.sv
`default_nettype none
// ============================================================================
// Module      : param_address_register_file
// Description : Bank of NUM_REGS address registers with shared operation,
//               active-low per-register enables and two combinational reads.
// Revision    : 1.0 - initial release
// ============================================================================
module param_address_register_file
    import addr_rf_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               NUM_REGS  = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               SEL_W     = sel_width(NUM_REGS)
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [WIDTH-1:0]      I,
    input  logic [c_FUNSEL_W-1:0] FunSel,
    input  logic [NUM_REGS-1:0]   RegSel,
    input  logic                  FlagClr,
    input  logic [SEL_W-1:0]      OutCSel,
    input  logic [SEL_W-1:0]      OutDSel,
    output logic [WIDTH-1:0]      OutC,
    output logic [WIDTH-1:0]      OutD,
    output logic [NUM_REGS-1:0]   WrapFlag
);

    logic [WIDTH-1:0] w_q [NUM_REGS];
    funsel_e          w_funsel;

    assign w_funsel = funsel_e'(FunSel);

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cell
            addr_reg_cell #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_cell (
                .clk        (Clock),
                .rst        (Reset),
                .i_data     (I),
                .i_funsel   (w_funsel),
                .i_en       (~RegSel[gi]),
                .i_flag_clr (FlagClr),
                .o_q        (w_q[gi]),
                .o_wrap     (WrapFlag[gi])
            );
        end
    endgenerate

    // Select codes with no backing register fall through to zero.
    always_comb begin
        OutC = '0;
        OutD = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (OutCSel == SEL_W'(i)) begin
                OutC = w_q[i];
            end
            if (OutDSel == SEL_W'(i)) begin
                OutD = w_q[i];
            end
        end
    end

endmodule : param_address_register_file
`default_nettype wire

// File: tb/tb_param_address_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_address_register_file
// Description : Self-checking bench for param_address_register_file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_address_register_file;

    logic        Clock;
    logic        Reset;
    logic [15:0] I;
    logic [2:0]  FunSel;
    logic [3:0]  RegSel;
    logic        FlagClr;
    logic [1:0]  OutCSel;
    logic [1:0]  OutDSel;
    logic [15:0] OutC;
    logic [15:0] OutD;
    logic [3:0]  WrapFlag;
    logic [15:0] OutC3;
    logic [15:0] OutD3;
    logic [2:0]  WrapFlag3;

    int count;
    int errors;

    logic [15:0] m_q [4];
    logic [3:0]  m_f;

    param_address_register_file #(.WIDTH(16), .NUM_REGS(4)) dut (
        .Clock(Clock), .Reset(Reset), .I(I), .FunSel(FunSel), .RegSel(RegSel),
        .FlagClr(FlagClr), .OutCSel(OutCSel), .OutDSel(OutDSel),
        .OutC(OutC), .OutD(OutD), .WrapFlag(WrapFlag)
    );

    param_address_register_file #(.WIDTH(16), .NUM_REGS(3)) dut3 (
        .Clock(Clock), .Reset(Reset), .I(I), .FunSel(FunSel), .RegSel(RegSel[2:0]),
        .FlagClr(FlagClr), .OutCSel(OutCSel), .OutDSel(OutDSel),
        .OutC(OutC3), .OutD(OutD3), .WrapFlag(WrapFlag3)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_q[i] = 16'h0000;
        m_f = 4'b0000;
    endfunction

    // Reference behaviour from the operation table, using integer arithmetic.
    function automatic void model_apply(input int fs, input int din, input logic [3:0] rs, input logic fc);
        int q, t, nq, lo;
        bit wrap, clr;
        for (int i = 0; i < 4; i++) begin
            q = int'(m_q[i]);
            nq = q;
            wrap = 0;
            lo = din % 256;
            if (!rs[i]) begin
                case (fs)
                    0: begin t = q - 1; wrap = (t < 0); nq = (t + 65536) % 65536; end
                    1: begin t = q + 1; wrap = (t > 65535); nq = t % 65536; end
                    2: nq = din;
                    3: nq = 0;
                    4: nq = lo;
                    5: nq = (q / 256) * 256 + lo;
                    6: nq = (din / 256) * 256 + (q % 256);
                    default: nq = (lo >= 128) ? (lo + 65536 - 256) : lo;
                endcase
            end
            clr = fc || (!rs[i] && (fs == 2 || fs == 3));
            m_q[i] = 16'(nq);
            if (wrap) m_f[i] = 1'b1;
            else if (clr) m_f[i] = 1'b0;
        end
    endfunction

    task automatic step(input logic [2:0] fs, input logic [15:0] din, input logic [3:0] rs, input logic fc);
        FunSel  = fs;
        I       = din;
        RegSel  = rs;
        FlagClr = fc;
        @(posedge Clock);
        model_apply(int'(fs), int'(din), rs, fc);
        #1;
        RegSel  = 4'b1111;
        FlagClr = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            OutCSel = 2'(i);
            OutDSel = 2'(3 - i);
            #1;
            count++;
            if (OutC !== 16'h0000 || OutD !== 16'h0000) begin
                errors++;
                $display("FAIL reset_read idx=%0d OutC=%h OutD=%h required 0000", i, OutC, OutD);
            end
        end
        count++;
        if (WrapFlag !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got=%b required 0000", WrapFlag);
        end
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic test_load();
        step(3'b010, 16'h1234, 4'b1011, 1'b0);
        OutCSel = 2'd2;
        #1;
        count++;
        if (OutC !== 16'h1234) begin
            errors++;
            $display("FAIL load_reg2 got=%h required 1234", OutC);
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 2) continue;
            OutDSel = 2'(i);
            #1;
            count++;
            if (OutD !== 16'h0000) begin
                errors++;
                $display("FAIL load_untouched idx=%0d got=%h required 0000", i, OutD);
            end
        end
    endtask

    task automatic test_wrap();
        OutCSel = 2'd0;
        step(3'b010, 16'hFFFF, 4'b1110, 1'b0);
        step(3'b001, 16'h0000, 4'b1110, 1'b0);
        count++;
        if (OutC !== 16'h0000 || WrapFlag !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_inc got=%h/%b required 0000/0001", OutC, WrapFlag);
        end
        step(3'b000, 16'h0000, 4'b1111, 1'b1);
        count++;
        if (WrapFlag !== 4'b0000) begin
            errors++;
            $display("FAIL flag_clear got=%b required 0000", WrapFlag);
        end
        step(3'b000, 16'h0000, 4'b1110, 1'b0);
        count++;
        if (OutC !== 16'hFFFF || WrapFlag !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_dec got=%h/%b required FFFF/0001", OutC, WrapFlag);
        end
        step(3'b000, 16'h0000, 4'b1111, 1'b1);
        step(3'b001, 16'h0000, 4'b1110, 1'b1);
        count++;
        if (OutC !== 16'h0000 || WrapFlag !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_vs_clear got=%h/%b required 0000/0001", OutC, WrapFlag);
        end
    endtask

    task automatic test_byte_ops();
        logic [15:0] exp_v [3];
        logic [2:0]  fs_v  [3];
        logic [15:0] in_v  [3];
        exp_v = '{16'hABCD, 16'hFF80, 16'h5580};
        fs_v  = '{3'b101, 3'b111, 3'b110};
        in_v  = '{16'h00CD, 16'h0080, 16'h5500};
        OutCSel = 2'd1;
        step(3'b010, 16'hAB00, 4'b1101, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(fs_v[k], in_v[k], 4'b1101, 1'b0);
            count++;
            if (OutC !== exp_v[k] || OutC !== m_q[1]) begin
                errors++;
                $display("FAIL byte_op%0d got=%h required %h", k, OutC, exp_v[k]);
            end
        end
    endtask

    task automatic test_multi_enable();
        step(3'b010, 16'h0001, 4'b0000, 1'b0);
        step(3'b001, 16'h0000, 4'b0000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            OutCSel = 2'(i);
            OutDSel = 2'((i + 1) % 4);
            #1;
            count++;
            if (OutC !== 16'h0002 || OutD !== 16'h0002 || WrapFlag !== 4'b0000) begin
                errors++;
                $display("FAIL multi_enable idx=%0d OutC=%h OutD=%h flags=%b required 0002/0002/0000",
                         i, OutC, OutD, WrapFlag);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] rs;
        int c, d;
        for (int n = 0; n < 300; n++) begin
            rs = (($urandom % 8) == 0) ? 4'b1111 : 4'($urandom);
            if (($urandom % 4) == 0) begin
                // Bias toward the wrap boundaries.
                step(3'b010, (($urandom % 2) == 0) ? 16'hFFFF : 16'h0000, rs, 1'b0);
                rs = 4'($urandom);
            end
            step(3'($urandom), 16'($urandom), rs, (($urandom % 8) == 0));
            c = int'($urandom % 4);
            d = int'($urandom % 4);
            OutCSel = 2'(c);
            OutDSel = 2'(d);
            #1;
            count++;
            if (OutC !== m_q[c] || OutD !== m_q[d] || WrapFlag !== m_f) begin
                errors++;
                $display("FAIL random n=%0d C[%0d]=%h D[%0d]=%h flags=%b required %h %h %b",
                         n, c, OutC, d, OutD, WrapFlag, m_q[c], m_q[d], m_f);
            end
        end
    endtask

    task automatic test_async_reset();
        step(3'b010, 16'hFFFF, 4'b0000, 1'b0);
        step(3'b001, 16'h0000, 4'b0000, 1'b0);
        step(3'b101, 16'h0077, 4'b0000, 1'b0);
        step(3'b110, 16'h7700, 4'b0000, 1'b0);
        OutCSel = 2'd1;
        OutDSel = 2'd3;
        #1;
        count++;
        if (OutC !== 16'h7777 || WrapFlag !== 4'b1111) begin
            errors++;
            $display("FAIL reset_setup got=%h/%b required 7777/1111", OutC, WrapFlag);
        end
        @(negedge Clock);
        #2;
        FunSel = 3'b001;
        RegSel = 4'b0000;
        Reset  = 1'b1;
        #1;
        model_reset();
        count++;
        if (OutC !== 16'h0000 || OutD !== 16'h0000 || WrapFlag !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset got=%h %h %b required 0000 0000 0000", OutC, OutD, WrapFlag);
        end
        @(posedge Clock);
        #1;
        count++;
        if (OutC !== 16'h0000 || WrapFlag !== 4'b0000) begin
            errors++;
            $display("FAIL reset_holds got=%h/%b required 0000/0000", OutC, WrapFlag);
        end
        @(negedge Clock);
        Reset = 1'b0;
        step(3'b001, 16'h0000, 4'b0000, 1'b0);
        count++;
        if (OutC !== 16'h0001 || OutD !== m_q[3]) begin
            errors++;
            $display("FAIL first_op_after_reset got=%h required 0001", OutC);
        end
    endtask

    task automatic test_out_of_range();
        step(3'b010, 16'hBEEF, 4'b0000, 1'b0);
        OutCSel = 2'd2;
        OutDSel = 2'd3;
        #1;
        count++;
        if (OutD3 !== 16'h0000 || OutC3 !== 16'hBEEF || OutD !== 16'hBEEF) begin
            errors++;
            $display("FAIL out_of_range OutD3=%h OutC3=%h OutD=%h required 0000 BEEF BEEF",
                     OutD3, OutC3, OutD);
        end
    endtask

    initial begin
        count   = 0;
        errors  = 0;
        Reset   = 1'b1;
        I       = 16'h0000;
        FunSel  = 3'b000;
        RegSel  = 4'b1111;
        FlagClr = 1'b0;
        OutCSel = 2'd0;
        OutDSel = 2'd0;
        model_reset();
        test_reset();
        test_load();
        test_wrap();
        test_byte_ops();
        test_multi_enable();
        test_random();
        test_async_reset();
        test_out_of_range();
        $display("End of test - %0d assertions evaluated, %0d failures", count, errors);
        $finish;
    end

endmodule : tb_param_address_register_file
`default_nettype wire
